// File: rtl/bf16_pkg.sv
// Shared constants, result-FIFO entry type and ID-width helper for the bf16 multiplier scheduler.
package bf16_pkg;

  localparam int unsigned BF16_W   = 16;
  localparam int unsigned MAX_ID_W = 4;
  localparam logic [BF16_W-1:0] BF16_ONE  = 16'h3F80;
  localparam logic [BF16_W-1:0] BF16_ZERO = 16'h0000;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [BF16_W-1:0]   data;
  } rsp_entry_t;

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/bf16_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer moves past the winner on en.
module bf16_rr_arbiter
  import bf16_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;
  int unsigned     idx;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!found && req[ID_W'(idx)]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
    gnt   = found ? (NUM_REQ'(1) << gnt_idx) : '0;
    ptr_d = en ? ID_W'((32'(gnt_idx) + 1) % NUM_REQ) : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bf16_mult_sched.sv
// Shares one pipelined bf16 multiplier among NUM_REQ requesters with credit-protected in-order result FIFO.
// Define BF16_SCHED_STATS_EN to add saturating issue/stall counters (stat_issue, stat_stall).
module bf16_mult_sched
  import bf16_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned MUL_LAT    = 2,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned ID_W       = id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BF16_W-1:0] req_a,
  input  logic [NUM_REQ*BF16_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BF16_W-1:0]         mul_a,
  output logic [BF16_W-1:0]         mul_b,
  input  logic [BF16_W-1:0]         mul_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [BF16_W-1:0]         rsp_data
`ifdef BF16_SCHED_STATS_EN
  ,
  output logic [31:0]               stat_issue,
  output logic [31:0]               stat_stall
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PTR_W = id_w(FIFO_DEPTH);

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               any_req_c, credit_ok_c, issue_c, stall_c, push_c, pop_c;
  logic [CNT_W-1:0]   inflight_c;

  logic [MUL_LAT-1:0] trk_vld_q, trk_vld_d;
  logic [ID_W-1:0]    trk_id_q [MUL_LAT];
  logic [ID_W-1:0]    trk_id_d [MUL_LAT];

  rsp_entry_t         mem_q [FIFO_DEPTH];
  rsp_entry_t         mem_d [FIFO_DEPTH];
  rsp_entry_t         head_c;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  bf16_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (issue_c),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Credits come from registered state only, so a pop never frees a slot in its own cycle.
  always_comb begin
    inflight_c = '0;
    for (int i = 0; i < MUL_LAT; i++) inflight_c = inflight_c + CNT_W'(trk_vld_q[i]);
    credit_ok_c = ((CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_c)) < (CNT_W+1)'(FIFO_DEPTH);
    any_req_c   = |req_valid;
    issue_c     = any_req_c && credit_ok_c && !rst;
    stall_c     = any_req_c && !credit_ok_c && !rst;
    req_ready   = issue_c ? gnt : '0;
    mul_a       = BF16_ZERO;
    mul_b       = BF16_ZERO;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        mul_a = req_a[BF16_W*i +: BF16_W];
        mul_b = req_b[BF16_W*i +: BF16_W];
      end
    end
  end

  // ID tracking pipe runs in lockstep with the multiplier; its last stage marks mul_out as valid.
  always_comb begin
    trk_vld_d    = '0;
    trk_id_d     = trk_id_q;
    trk_vld_d[0] = issue_c;
    trk_id_d[0]  = gnt_idx;
    for (int i = 1; i < MUL_LAT; i++) begin
      trk_vld_d[i] = trk_vld_q[i-1];
      trk_id_d[i]  = trk_id_q[i-1];
    end
  end

  always_comb begin
    head_c    = mem_q[rd_ptr_q];
    rsp_valid = (count_q != '0);
    rsp_id    = rsp_valid ? ID_W'(head_c.id) : '0;
    rsp_data  = rsp_valid ? head_c.data : BF16_ZERO;
    push_c    = trk_vld_q[MUL_LAT-1];
    pop_c     = rsp_valid && rsp_ready;
    mem_d     = mem_q;
    if (push_c) mem_d[wr_ptr_q] = '{id: MAX_ID_W'(trk_id_q[MUL_LAT-1]), data: mul_out};
    wr_ptr_d  = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trk_vld_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      trk_vld_q <= trk_vld_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    trk_id_q <= trk_id_d;
    mem_q    <= mem_d;
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_c && count_q == CNT_W'(FIFO_DEPTH)));

`ifdef BF16_SCHED_STATS_EN
  logic [31:0] stat_issue_q, stat_issue_d, stat_stall_q, stat_stall_d;

  always_comb begin
    stat_issue_d = stat_issue_q;
    stat_stall_d = stat_stall_q;
    if (issue_c && stat_issue_q != '1) stat_issue_d = stat_issue_q + 32'd1;
    if (stall_c && stat_stall_q != '1) stat_stall_d = stat_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issue_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_issue_q <= stat_issue_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_issue = stat_issue_q;
  assign stat_stall = stat_stall_q;
`else
  logic unused_stall;
  assign unused_stall = stall_c;
`endif

endmodule

// File: tb/tb_bf16_mult_sched.sv
// Self-checking bench for bf16_mult_sched: transaction-level model of arbitration, credits and result order.
module tb_bf16_mult_sched;

  localparam int N     = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [3:0]  req_ready;
  logic [15:0] mul_a, mul_b, mul_out;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
`ifdef BF16_SCHED_STATS_EN
  logic [31:0] stat_issue, stat_stall;
`endif

  always #5 clk = ~clk;

  bf16_mult_sched #(.NUM_REQ(N), .MUL_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_out   (mul_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef BF16_SCHED_STATS_EN
    ,
    .stat_issue(stat_issue),
    .stat_stall(stat_stall)
`endif
  );

  // Truncating bf16 multiply for normal operands (and signed zero).
  function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    int          e;
    logic [15:0] m;
    logic [6:0]  frac;
    s = a[15] ^ b[15];
    if (a[14:0] == 15'h0 || b[14:0] == 15'h0) return {s, 15'h0};
    e = int'(a[14:7]) + int'(b[14:7]) - 127;
    m = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
    if (m[15]) begin frac = m[14:8]; e = e + 1; end
    else       frac = m[13:7];
    return {s, 8'(e), frac};
  endfunction

  function automatic logic [63:0] rnd_ops();
    logic [63:0] r;
    for (int i = 0; i < N; i++)
      r[16*i +: 16] = {1'($urandom), 8'($urandom_range(150, 100)), 7'($urandom)};
    return r;
  endfunction

  // External multiplier: operands captured at an edge appear on mul_out LAT cycles later.
  logic [15:0] mpipe [LAT] = '{default: 16'h0};
  always @(posedge clk) begin
    mpipe[0] <= bf16_mul(mul_a, mul_b);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_out = mpipe[LAT-1];

  // Reference model: outstanding = issued - popped; every result ready LAT+1 cycles after issue.
  typedef struct { logic [1:0] id; logic [15:0] data; int rdy; } exp_t;
  exp_t        q[$];
  int          m_ptr = 0, m_out = 0, m_cyc = 0;
  int unsigned m_issue = 0, m_stall = 0;
  logic        p_rst = 1'b1, p_issue = 1'b0, p_pop = 1'b0, p_stall = 1'b0;
  int          p_gnt = 0;
  logic [15:0] p_a = '0, p_b = '0;
  logic [3:0]  e_ready;
  logic [15:0] e_mul_a, e_mul_b, e_data;
  logic        e_valid;
  logic [1:0]  e_id;
  int          n_checks = 0, n_pass = 0;

  task automatic cyc(input logic r, input logic [3:0] v, input logic [63:0] a,
                     input logic [63:0] b, input logic rr);
    @(posedge clk);
    if (p_rst) begin
      q.delete(); m_ptr = 0; m_out = 0; m_issue = 0; m_stall = 0;
    end else begin
      if (p_pop) begin void'(q.pop_front()); m_out--; end
      if (p_issue) begin
        q.push_back('{id: 2'(p_gnt), data: bf16_mul(p_a, p_b), rdy: m_cyc + LAT + 1});
        m_ptr = (p_gnt + 1) % N;
        m_out++;
        if (m_issue != 32'hFFFF_FFFF) m_issue++;
      end
      if (p_stall && m_stall != 32'hFFFF_FFFF) m_stall++;
    end
    m_cyc++;
    #1;
    rst = r; req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
    p_rst = r; p_issue = 1'b0; p_gnt = 0; p_a = '0; p_b = '0;
    if (v != 4'h0 && m_out < DEPTH && !r) begin
      p_issue = 1'b1;
      for (int k = N - 1; k >= 0; k--) if (v[(m_ptr + k) % N]) p_gnt = (m_ptr + k) % N;
      p_a = a[16*p_gnt +: 16];
      p_b = b[16*p_gnt +: 16];
    end
    p_stall = (v != 4'h0) && m_out >= DEPTH && !r;
    e_ready = p_issue ? 4'(1 << p_gnt) : 4'h0;
    e_mul_a = p_a;
    e_mul_b = p_b;
    e_valid = q.size() > 0 && q[0].rdy <= m_cyc;
    e_id    = e_valid ? q[0].id : 2'd0;
    e_data  = e_valid ? q[0].data : 16'h0;
    p_pop   = e_valid && rr && !r;
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 4'h0, '0, '0, 1'b1);
    cyc(1'b1, 4'hF, rnd_ops(), rnd_ops(), 1'b1);
    n_checks++; if (req_ready !== 4'h0) $display("FAIL reset_ready got=%b exp=0000", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_id !== 2'd0) $display("FAIL reset_id got=%0d exp=0", rsp_id); else n_pass++;
    n_checks++; if (rsp_data !== 16'h0) $display("FAIL reset_data got=%h exp=0000", rsp_data); else n_pass++;
`ifdef BF16_SCHED_STATS_EN
    n_checks++; if (stat_issue !== 32'd0) $display("FAIL reset_stat_issue got=%0d exp=0", stat_issue); else n_pass++;
`endif
    cyc(1'b0, 4'h0, '0, '0, 1'b1);
  endtask

  task automatic test_single();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) cyc(1'b0, 4'b0001, {48'h0, 16'h3F80}, {48'h0, 16'h4000}, 1'b1);
      else        cyc(1'b0, 4'b0000, '0, '0, 1'b1);
      n_checks++; if (req_ready !== e_ready) $display("FAIL single_ready c=%0d got=%b exp=%b", i, req_ready, e_ready); else n_pass++;
      n_checks++; if (mul_a !== e_mul_a || mul_b !== e_mul_b) $display("FAIL single_mul c=%0d got=%h/%h exp=%h/%h", i, mul_a, mul_b, e_mul_a, e_mul_b); else n_pass++;
      n_checks++; if (rsp_valid !== e_valid) $display("FAIL single_valid c=%0d got=%b exp=%b", i, rsp_valid, e_valid); else n_pass++;
      if (i == 3) begin
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'h4000) $display("FAIL single_rsp got=%b/%0d/%h exp=1/0/4000", rsp_valid, rsp_id, rsp_data); else n_pass++;
      end
    end
  endtask

  task automatic test_rr_all();
    cyc(1'b1, 4'h0, '0, '0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, (i < 8) ? 4'hF : 4'h0, rnd_ops(), rnd_ops(), 1'b1);
      n_checks++; if (req_ready !== e_ready) $display("FAIL rr_ready c=%0d got=%b exp=%b", i, req_ready, e_ready); else n_pass++;
      n_checks++; if (mul_a !== e_mul_a || mul_b !== e_mul_b) $display("FAIL rr_mul c=%0d got=%h/%h exp=%h/%h", i, mul_a, mul_b, e_mul_a, e_mul_b); else n_pass++;
      n_checks++; if (rsp_valid !== e_valid || rsp_id !== e_id || rsp_data !== e_data) $display("FAIL rr_rsp c=%0d got=%b/%0d/%h exp=%b/%0d/%h", i, rsp_valid, rsp_id, rsp_data, e_valid, e_id, e_data); else n_pass++;
    end
  endtask

  task automatic test_skip();
    logic [3:0] vt [9];
    vt = '{4'b0001, 4'b0101, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    cyc(1'b1, 4'h0, '0, '0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, vt[i], rnd_ops(), rnd_ops(), 1'b1);
      n_checks++; if (req_ready !== e_ready) $display("FAIL skip_ready c=%0d got=%b exp=%b", i, req_ready, e_ready); else n_pass++;
      n_checks++; if (rsp_valid !== e_valid || rsp_id !== e_id || rsp_data !== e_data) $display("FAIL skip_rsp c=%0d got=%b/%0d/%h exp=%b/%0d/%h", i, rsp_valid, rsp_id, rsp_data, e_valid, e_id, e_data); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    cyc(1'b1, 4'h0, '0, '0, 1'b0);
    for (int i = 0; i < 26; i++) begin
      cyc(1'b0, (i < 16) ? 4'hF : 4'h0, rnd_ops(), rnd_ops(), i >= 10);
`ifdef BF16_SCHED_STATS_EN
      if (i == 10) begin
        n_checks++; if (stat_issue !== 32'(m_issue) || stat_stall !== 32'(m_stall)) $display("FAIL bp_stats got=%0d/%0d exp=%0d/%0d", stat_issue, stat_stall, m_issue, m_stall); else n_pass++;
      end
`endif
      n_checks++; if (req_ready !== e_ready) $display("FAIL bp_ready c=%0d got=%b exp=%b", i, req_ready, e_ready); else n_pass++;
      n_checks++; if (rsp_valid !== e_valid || rsp_id !== e_id || rsp_data !== e_data) $display("FAIL bp_rsp c=%0d got=%b/%0d/%h exp=%b/%0d/%h", i, rsp_valid, rsp_id, rsp_data, e_valid, e_id, e_data); else n_pass++;
    end
  endtask

  task automatic test_products();
    logic [15:0] lit [2];
    int          k;
    lit = '{16'h4040, 16'hBF80};
    k = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      cyc(1'b0, 4'b0010, {32'h0, 16'h3FC0, 16'h0}, {32'h0, 16'h4000, 16'h0}, 1'b1);
      else if (i == 1) cyc(1'b0, 4'b1000, {16'hBF80, 48'h0}, {16'h3F80, 48'h0}, 1'b1);
      else             cyc(1'b0, 4'b0000, '0, '0, 1'b1);
      n_checks++; if (rsp_valid !== e_valid || rsp_id !== e_id || rsp_data !== e_data) $display("FAIL prod_rsp c=%0d got=%b/%0d/%h exp=%b/%0d/%h", i, rsp_valid, rsp_id, rsp_data, e_valid, e_id, e_data); else n_pass++;
      if (rsp_valid === 1'b1 && k < 2) begin
        n_checks++; if (rsp_data !== lit[k]) $display("FAIL prod_value k=%0d got=%h exp=%h", k, rsp_data, lit[k]); else n_pass++;
        k++;
      end
    end
    n_checks++; if (k != 2) $display("FAIL prod_count got=%0d exp=2", k); else n_pass++;
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 4'h0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'hF, rnd_ops(), rnd_ops(), 1'b0);
    cyc(1'b1, 4'h0, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 4'h0, '0, '0, 1'b1);
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rmid_valid c=%0d got=%b exp=0", i, rsp_valid); else n_pass++;
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, (i == 0) ? 4'hF : 4'h0, rnd_ops(), rnd_ops(), 1'b1);
      if (i == 0) begin
        n_checks++; if (req_ready !== 4'b0001) $display("FAIL rmid_ptr got=%b exp=0001", req_ready); else n_pass++;
      end
      n_checks++; if (rsp_valid !== e_valid || rsp_id !== e_id || rsp_data !== e_data) $display("FAIL rmid_rsp c=%0d got=%b/%0d/%h exp=%b/%0d/%h", i, rsp_valid, rsp_id, rsp_data, e_valid, e_id, e_data); else n_pass++;
    end
  endtask

  task automatic test_random();
    cyc(1'b1, 4'h0, '0, '0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      cyc(1'b0, 4'($urandom), rnd_ops(), rnd_ops(), (i >= 190) || ($urandom_range(0, 3) != 0));
      n_checks++; if (req_ready !== e_ready) $display("FAIL rnd_ready c=%0d got=%b exp=%b", i, req_ready, e_ready); else n_pass++;
      n_checks++; if (mul_a !== e_mul_a || mul_b !== e_mul_b) $display("FAIL rnd_mul c=%0d got=%h/%h exp=%h/%h", i, mul_a, mul_b, e_mul_a, e_mul_b); else n_pass++;
      n_checks++; if (rsp_valid !== e_valid || rsp_id !== e_id || rsp_data !== e_data) $display("FAIL rnd_rsp c=%0d got=%b/%0d/%h exp=%b/%0d/%h", i, rsp_valid, rsp_id, rsp_data, e_valid, e_id, e_data); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_all();
    test_skip();
    test_backpressure();
    test_products();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
